// File: rtl/uart_rx_endpoint.sv
// uart_rx_endpoint: UART receiver with a single-entry holding register and one-cycle error pulses.
// Frame format is 8N1 by default; defining UART_RX_PARITY_EN switches it to 8E1.
module uart_rx_endpoint #(
   parameter int unsigned CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       frame_err,
   output logic       overrun,
   output logic       parity_err
);
   localparam int unsigned   CW          = $clog2(CLKS_PER_BIT) + 1;
   localparam logic [CW-1:0] FULL_RELOAD = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_RELOAD = CW'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t        r_state, w_next;
   logic          r_sync1, r_rx_s, r_rx_prev;
   logic [CW-1:0] r_cnt;
   logic [2:0]    r_bit_idx;
   logic [7:0]    r_shift;
   logic [7:0]    r_rx_data;
   logic          r_rx_valid, r_frame_err, r_overrun;
   logic          w_fall, w_tick, w_load_half, w_load_full;
   logic          w_data_smp, w_stop_smp, w_par_bad, w_deliver;

   assign w_fall    = r_rx_prev & ~r_rx_s;
   assign w_tick    = (r_cnt == '0);
   assign w_deliver = w_stop_smp & r_rx_s & ~w_par_bad;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1   <= 1'b1;
         r_rx_s    <= 1'b1;
         r_rx_prev <= 1'b1;
      end else begin
         r_sync1   <= rx;
         r_rx_s    <= r_sync1;
         r_rx_prev <= r_rx_s;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_fall) w_next = START;
         START:   if (w_tick) w_next = r_rx_s ? IDLE : DATA;
         DATA:    if (w_tick && r_bit_idx == 3'd7)
`ifdef UART_RX_PARITY_EN
                     w_next = PARITY;
`else
                     w_next = STOP;
`endif
         PARITY:  if (w_tick) w_next = STOP;
         STOP:    if (w_tick) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

`ifdef UART_RX_PARITY_EN
   logic w_par_smp;
`endif

   always_comb begin
      w_load_half = 1'b0;
      w_load_full = 1'b0;
      w_data_smp  = 1'b0;
      w_stop_smp  = 1'b0;
`ifdef UART_RX_PARITY_EN
      w_par_smp   = 1'b0;
`endif
      case (r_state)
         IDLE:  w_load_half = w_fall;
         START: w_load_full = w_tick & ~r_rx_s;
         DATA: begin
            w_data_smp  = w_tick;
            w_load_full = w_tick;
         end
         PARITY: begin
`ifdef UART_RX_PARITY_EN
            w_par_smp   = w_tick;
`endif
            w_load_full = w_tick;
         end
         STOP:    w_stop_smp = w_tick;
         default: ;
      endcase
   end

   // Counter reloads on every sample; reaching zero marks the next sample point.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)               r_cnt <= '0;
      else if (w_load_half)     r_cnt <= HALF_RELOAD;
      else if (w_load_full)     r_cnt <= FULL_RELOAD;
      else if (r_cnt != '0)     r_cnt <= r_cnt - CW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bit_idx <= '0;
         r_shift   <= '0;
      end else if (w_load_half) begin
         r_bit_idx <= '0;
      end else if (w_data_smp) begin
         r_bit_idx <= r_bit_idx + 3'd1;
         r_shift   <= {r_rx_s, r_shift[7:1]};
      end
   end

`ifdef UART_RX_PARITY_EN
   logic r_par_bad, r_parity_err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_par_bad    <= 1'b0;
         r_parity_err <= 1'b0;
      end else begin
         if (w_load_half)    r_par_bad <= 1'b0;
         else if (w_par_smp) r_par_bad <= ^{r_rx_s, r_shift};
         r_parity_err <= w_stop_smp & r_par_bad;
      end
   end

   assign w_par_bad  = r_par_bad;
   assign parity_err = r_parity_err;
`else
   assign w_par_bad  = 1'b0;
   assign parity_err = 1'b0;
`endif

   // A delivery coinciding with a handshake replaces the byte instead of overrunning.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rx_data   <= '0;
         r_rx_valid  <= 1'b0;
         r_frame_err <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         r_frame_err <= w_stop_smp & ~r_rx_s;
         r_overrun   <= w_deliver & r_rx_valid & ~rx_ready;
         if (w_deliver && (!r_rx_valid || rx_ready)) begin
            r_rx_data  <= r_shift;
            r_rx_valid <= 1'b1;
         end else if (r_rx_valid && rx_ready) begin
            r_rx_valid <= 1'b0;
         end
      end
   end

   assign rx_data   = r_rx_data;
   assign rx_valid  = r_rx_valid;
   assign frame_err = r_frame_err;
   assign overrun   = r_overrun;
endmodule

// File: tb/tb_uart_rx_endpoint.sv
// Scoreboard bench for uart_rx_endpoint: directed frames push expected events with their cycle,
// a negedge monitor pops and compares each delivery / error pulse the DUT presents.
`timescale 1ns/1ps
module tb_uart_rx_endpoint;
   localparam int CLKS = 16;
`ifdef UART_RX_PARITY_EN
   localparam int FRAME = 176;
   localparam int LAT   = 171;
`else
   localparam int FRAME = 160;
   localparam int LAT   = 155;
`endif
   localparam int K_DATA = 0;
   localparam int K_FERR = 1;
   localparam int K_PERR = 2;
   localparam int K_OVR  = 3;

   typedef struct {
      int         kind;
      logic [7:0] data;
      int         cyc;
   } ev_t;

   logic       clk = 1'b0;
   logic       rst_n, rx, rx_ready;
   logic [7:0] rx_data;
   logic       rx_valid, frame_err, overrun, parity_err;

   int   cyc = 0;
   int   tests = 0;
   int   fails = 0;
   ev_t  sb[$];
   logic pv, pr;
   logic [7:0] pdata;
   int   p, q;

   uart_rx_endpoint #(.CLKS_PER_BIT(CLKS)) dut (
      .clk(clk), .rst_n(rst_n), .rx(rx),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .frame_err(frame_err), .overrun(overrun), .parity_err(parity_err)
   );

   initial forever #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(input int k, input logic [7:0] d, input int c);
      ev_t e;
      e.kind = k; e.data = d; e.cyc = c;
      sb.push_back(e);
   endtask

   task automatic expect_ev(input int k, input logic [7:0] d);
      ev_t e;
      tests++;
      if (sb.size() == 0) begin
         fails++;
         $display("FAIL unexpected_event: got kind=%0d data=%0h at cycle %0d, expected none", k, d, cyc);
      end else begin
         e = sb.pop_front();
         if (e.kind != k || e.data !== d || e.cyc != cyc) begin
            fails++;
            $display("FAIL event: got kind=%0d data=%0h cyc=%0d, expected kind=%0d data=%0h cyc=%0d",
                     k, d, cyc, e.kind, e.data, e.cyc);
         end
      end
   endtask

   initial begin
      pv = 1'b0; pr = 1'b0; pdata = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            pv = 1'b0; pr = 1'b0;
         end else begin
            if (rx_valid && (!pv || pr)) expect_ev(K_DATA, rx_data);
            if (pv && !pr) begin
               check("valid_held", {31'd0, rx_valid}, 32'd1);
               check("data_stable", {24'd0, rx_data}, {24'd0, pdata});
            end
            if (frame_err)  expect_ev(K_FERR, 8'h00);
            if (parity_err) expect_ev(K_PERR, 8'h00);
            if (overrun)    expect_ev(K_OVR, 8'h00);
            pv = rx_valid; pr = rx_ready; pdata = rx_data;
         end
      end
   end

   function automatic logic par_of(input logic [7:0] d);
      return ^d;
   endfunction

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive_bit(input logic b);
      rx = b;
      idle(CLKS);
   endtask

   task automatic send(input logic [7:0] d, input logic par, input logic stop);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
      drive_bit(par);
`else
      if (par === 1'bx) rx = 1'b1;
`endif
      drive_bit(stop);
      rx = 1'b1;
   endtask

   task automatic send_good(input logic [7:0] d);
      push(K_DATA, d, cyc + LAT);
      send(d, par_of(d), 1'b1);
   endtask

   task automatic consume(input string name);
      check({name, "_valid_before"}, {31'd0, rx_valid}, 32'd1);
      rx_ready = 1'b1;
      idle(1);
      rx_ready = 1'b0;
      check({name, "_valid_after"}, {31'd0, rx_valid}, 32'd0);
   endtask

   initial begin
      logic [7:0] d;
      rst_n = 1'b0; rx = 1'b1; rx_ready = 1'b0;
      idle(3);
      check("rst_valid", {31'd0, rx_valid}, 32'd0);
      check("rst_data", {24'd0, rx_data}, 32'h00);
      check("rst_errs", {29'd0, frame_err, overrun, parity_err}, 32'd0);
      rst_n = 1'b1;
      idle(10);

      // basic 0xA5 with exact latency, held then consumed
      send_good(8'hA5);
      idle(20);
      check("a5_hold_valid", {31'd0, rx_valid}, 32'd1);
      check("a5_hold_data", {24'd0, rx_data}, 32'hA5);
      consume("a5");
      idle(10);

      // 5-cycle low glitch, then 0x3C
      rx = 1'b0;
      idle(5);
      rx = 1'b1;
      idle(40);
      check("glitch_no_valid", {31'd0, rx_valid}, 32'd0);
      send_good(8'h3C);
      idle(5);
      check("3c_data", {24'd0, rx_data}, 32'h3C);
      consume("3c");

      // boundary byte values
      send_good(8'h00);
      idle(5);
      consume("x00");
      send_good(8'hFF);
      idle(5);
      consume("xff");

      // bad stop bit
      push(K_FERR, 8'h00, cyc + LAT);
      send(8'h81, par_of(8'h81), 1'b0);
      idle(40);
      check("ferr_no_valid", {31'd0, rx_valid}, 32'd0);

      // back-to-back with consumer stalled -> overrun, first byte kept
      p = cyc;
      push(K_DATA, 8'h11, p + LAT);
      push(K_OVR, 8'h00, p + FRAME + LAT);
      send(8'h11, par_of(8'h11), 1'b1);
      send(8'h22, par_of(8'h22), 1'b1);
      idle(10);
      check("ovr_keep_data", {24'd0, rx_data}, 32'h11);
      consume("ovr");
      idle(10);

      // back-to-back with handshake on the second delivery edge -> replace, no overrun
      q = cyc;
      push(K_DATA, 8'h11, q + LAT);
      push(K_DATA, 8'h22, q + FRAME + LAT);
      fork
         begin
            send(8'h11, par_of(8'h11), 1'b1);
            send(8'h22, par_of(8'h22), 1'b1);
         end
         begin
            idle(FRAME + LAT - 1);
            rx_ready = 1'b1;
            idle(1);
            rx_ready = 1'b0;
         end
      join
      idle(10);
      check("hs_new_data", {24'd0, rx_data}, 32'h22);
      consume("hs");
      idle(10);

      // reset in the middle of data bit 4 of 0x55
      d = 8'h55;
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(d[i]);
      rx = d[4];
      idle(CLKS / 2);
      rst_n = 1'b0;
      rx = 1'b1;
      idle(2);
      check("midrst_data", {24'd0, rx_data}, 32'h00);
      check("midrst_valid", {31'd0, rx_valid}, 32'd0);
      check("midrst_errs", {29'd0, frame_err, overrun, parity_err}, 32'd0);
      rst_n = 1'b1;
      idle(200);
      check("midrst_no_delivery", {31'd0, rx_valid}, 32'd0);
      send_good(8'hF0);
      idle(5);
      check("f0_data", {24'd0, rx_data}, 32'hF0);
      consume("f0");

`ifdef UART_RX_PARITY_EN
      push(K_DATA, 8'h07, cyc + LAT);
      send(8'h07, 1'b1, 1'b1);
      idle(5);
      check("par_ok_data", {24'd0, rx_data}, 32'h07);
      consume("par_ok");
      push(K_PERR, 8'h00, cyc + LAT);
      send(8'h07, 1'b0, 1'b1);
      idle(20);
      check("perr_no_valid", {31'd0, rx_valid}, 32'd0);
      push(K_FERR, 8'h00, cyc + LAT);
      push(K_PERR, 8'h00, cyc + LAT);
      send(8'h07, 1'b0, 1'b0);
      idle(20);
      check("both_no_valid", {31'd0, rx_valid}, 32'd0);
`endif

      idle(20);
      check("sb_empty", sb.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not complete, expected finish before 2ms");
      $fatal(1);
   end
endmodule

// File: doc/uart_rx_endpoint.md
UART_RX_ENDPOINT -- requirements
Module: uart_rx_endpoint

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16: clk cycles per UART bit; legal range 4..4095, even values only.
REQ-002 SHALL have port clk  input  1  rising-edge system clock.
REQ-003 SHALL have port rst_n  input  1  reset; one clock, asynchronous assert, active-low.
REQ-004 SHALL have port rx  input  1  UART serial line, idle high, asynchronous to clk.
REQ-005 SHALL have port rx_data  output  8  received byte; valid only while rx_valid=1.
REQ-006 SHALL have port rx_valid  output  1  holding register contains an unconsumed byte.
REQ-007 SHALL have port rx_ready  input  1  consumer accepts the byte when rx_valid=1 and rx_ready=1 at a rising edge.
REQ-008 SHALL have port frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-009 SHALL have port overrun  output  1  one-cycle pulse: completed byte dropped because the holding register was full.
REQ-010 SHALL have port parity_err  output  1  one-cycle pulse: parity mismatch (see Configuration).

Function
REQ-011 SHALL pass rx through a 2-flop synchronizer; all logic uses the synchronized value rx_s.
REQ-012 SHALL have FSM states IDLE, START, DATA, PARITY, STOP.
REQ-013 IDLE -> START SHALL occur on a detected falling edge of rx_s (previous 1, current 0); the detect cycle is t0.
REQ-014 START SHALL sample rx_s at t0+CLKS_PER_BIT/2; if 1 -> IDLE (glitch, no outputs); if 0 -> DATA.
REQ-015 DATA SHALL sample 8 bits LSB-first, each CLKS_PER_BIT cycles after the previous sample.
REQ-016 After bit 7 the FSM SHALL go to PARITY if RX_PARITY_EN is defined, else to STOP.
REQ-017 STOP SHALL sample once, CLKS_PER_BIT cycles after the last sample; then -> IDLE.
REQ-018 Stop sample 1 with no parity error SHALL deliver the byte; stop sample 0 SHALL pulse frame_err the next cycle and discard the byte.
REQ-019 Delivery SHALL load rx_data and set rx_valid on the cycle after the stop sample.
REQ-020 rx_valid SHALL clear on the handshake cycle; rx_data SHALL stay stable while rx_valid=1.
REQ-021 If delivery occurs while rx_valid=1 and rx_ready=0, the SHALL keep the old byte and pulse overrun.
REQ-022 If delivery coincides with a handshake, the old byte SHALL be consumed, the new byte loaded, rx_valid SHALL stay 1, and no overrun SHALL occur.
REQ-023 Leaving STOP -> IDLE SHALL allow immediate start detection, so back-to-back frames are received.
REQ-024 A falling edge while not in IDLE SHALL be ignored.
REQ-025 The baud counter SHALL be clog2(CLKS_PER_BIT)+1 bits wide and reload on every sample; there SHALL be no fractional-rate correction.

Reset
REQ-026 rst_n=0 SHALL immediately force IDLE, counters to 0, the synchronizer and edge flops to 1, rx_data=8'h00, rx_valid=0, and frame_err/overrun/parity_err=0.
REQ-027 Reset mid-frame SHALL abort the frame with no outputs; after release, a frame needs a fresh falling edge.
REQ-028 Reset deassertion SHALL be the only synchronous-to-clk requirement; the integration synchronizes its release.

Configuration
REQ-029 Macro UART_RX_PARITY_EN defined: the frame SHALL be 8E1; PARITY samples one bit CLKS_PER_BIT after bit 7, even parity over the data byte plus the parity bit.
REQ-030 On mismatch with a good stop bit, the block SHALL pulse parity_err and discard the byte.
REQ-031 If both the stop bit and parity fail, frame_err and parity_err SHALL both pulse in the same cycle.
REQ-032 Macro undefined: the frame SHALL be 8N1, the PARITY state SHALL be unreachable, and parity_err SHALL be tied 0.

Verification
REQ-033 8N1, CLKS_PER_BIT=16: drive 0xA5 on rx at pin time p -> rx_valid=1 with rx_data=0xA5 at cycle p+155; hold with rx_ready=0, then pulse rx_ready -> rx_valid=0 next cycle.
REQ-034 Low glitch of 5 cycles on rx -> no rx_valid/frame_err; FSM returns to IDLE; a following 0x3C is received correctly.
REQ-035 Frame 0x81 with the stop bit driven 0 -> frame_err pulses 1 cycle, rx_valid stays 0.
REQ-036 Bytes 0x11, 0x22 back-to-back with rx_ready=0 -> rx_data=0x11 and an overrun pulse; repeat with rx_ready=1 asserted on the second delivery cycle -> rx_data=0x22 and no overrun.
REQ-037 rst_n low at data bit 4 of 0x55, then release -> all outputs at reset values and no delivery; the next frame 0xF0 is received correctly.
REQ-038 UART_RX_PARITY_EN: 0x07 with parity bit 1 -> delivered; 0x07 with parity bit 0 -> parity_err pulse and no rx_valid.
